stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Button front-end and run-control FSM that sits directly upstream of the stopwatch digit counter.
- Synchronises and debounces two push-buttons: start/stop and lap/clear.
- Gates the 10 Hz enable into the digit counter, issues a synchronous clear pulse, and drives a display-hold level so a lap time can be frozen on the seven-segment display while counting continues.

Parameters:
- DB_CYCLES, 2000000, consecutive stable clk cycles needed to accept a button level change (20 ms at 100 MHz).
- CNT_W, 21, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset.
- btn_ss, input, 1, start/stop button, active-high, asynchronous to clk.
- btn_lap, input, 1, lap/clear button, active-high, asynchronous to clk.
- tick_in, input, 1, 10 Hz one-cycle enable from the tick generator.
- tick_out, output, 1, gated enable to the digit counter.
- clear, output, 1, one-cycle synchronous clear to the digit counter.
- hold, output, 1, display-freeze level to the display path.
- state, output, 2, current FSM state, for debug LEDs.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hold=0; clear=0.
  - Synchroniser flops, debounced levels and debounce counters all 0.
  - tick_out=0, because it is decoded from state.
- Synchronisation: each button passes through 2 flops before use.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level.
  - Any cycle where they match resets the counter to 0.
  - When the counter reaches DB_CYCLES-1 and the levels still differ, the debounced level toggles and the counter returns to 0.
  - A press event is a one-cycle pulse on the debounced 0->1 transition. Releases generate no event.
- Latency: a clean input step produces the state/hold update exactly DB_CYCLES+3 clk edges later.
- State encoding: IDLE=00, RUN=01, LAP=10, PAUSE=11. FSM transitions only on press events.
  - IDLE: ss -> RUN. lap -> IDLE with clear pulse.
  - RUN: ss -> PAUSE. lap -> LAP.
  - LAP: ss -> PAUSE. lap -> RUN.
  - PAUSE: ss -> RUN. lap -> IDLE with clear pulse.
- Simultaneous ss and lap events in the same cycle: ss wins and the lap event is discarded.
- tick_out = tick_in AND (state==RUN OR state==LAP). It is combinational from the state register, with zero added latency.
  - A tick coinciding with the edge that changes state uses the pre-edge state.
- hold:
  - Registered: hold=1 exactly while state==LAP.
  - Entering PAUSE from LAP drops hold, so the display shows the live stopped count.
- clear:
  - Registered: high for exactly one cycle, coincident with the first cycle state==IDLE after a lap event from PAUSE or IDLE.
  - Never asserted by reset.
- Button held through reset release: the debounced level starts at 0, so a press event fires DB_CYCLES+3 edges after release. This is intended.
- Glitches shorter than DB_CYCLES cycles never produce an event.
- Reset mid-debounce discards the partial count.
- Counter width: the debounce counter never exceeds DB_CYCLES-1 and never wraps.

Test Plan (DB_CYCLES=4 in simulation):
- Reset release, no buttons, tick_in pulsing every 10 cycles -> state=00, tick_out=0, hold=0, clear=0 throughout.
- Clean btn_ss press held for 10 cycles -> state=01 exactly 7 edges after the press; the next tick_in pulses appear on tick_out. A second press gives state=11 and tick_out=0.
- RUN, then btn_lap press -> state=10, hold=1, tick_out still follows tick_in. A second lap press gives state=01 and hold=0.
- PAUSE, then btn_lap press -> state=00 and clear=1 for exactly one cycle in that same cycle. A further lap press in IDLE gives another single clear pulse.
- btn_ss glitches of 1, 2 and 3 cycles separated by low gaps -> no state change. A 4-cycle-stable pulse changes state once.
- btn_ss and btn_lap rising on the same cycle while in RUN -> state=11, hold stays 0. Asserting rst=0 mid-debounce returns all outputs to reset values immediately, with no event after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button front-end: two-flop synchronisers, per-button debounce,
// and the run-control FSM that gates the 10 Hz tick, clears and holds the display.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 2000000,
  parameter int CNT_W     = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       tick_in,
  output logic       tick_out,
  output logic       clear,
  output logic       hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Bit 0 carries start/stop, bit 1 carries lap/clear.
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       db_p2;
  logic [1:0]       press_p2;
  logic [CNT_W-1:0] cnt_p2 [2];

  state_t st_q;
  state_t st_d;
  logic   hold_d;
  logic   clear_d;
  logic   ev_ss;
  logic   ev_lap;

  // Stage p0/p1: synchroniser; stage p2: debounce and press detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_p2    <= '0;
      press_p2 <= '0;
      for (int i = 0; i < 2; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= {btn_lap, btn_ss};
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        press_p2[i] <= 1'b0;
        if (sync_p1[i] == db_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          db_p2[i]    <= ~db_p2[i];
          cnt_p2[i]   <= '0;
          press_p2[i] <= ~db_p2[i];
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Start/stop takes precedence when both presses land together.
  assign ev_ss  = press_p2[0];
  assign ev_lap = press_p2[1] & ~press_p2[0];

  // Stage p3: run-control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      hold  <= 1'b0;
      clear <= 1'b0;
    end else begin
      st_q  <= st_d;
      hold  <= hold_d;
      clear <= clear_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (ev_ss) begin
      case (st_q)
        IDLE:    st_d = RUN;
        RUN:     st_d = PAUSE;
        LAP:     st_d = PAUSE;
        PAUSE:   st_d = RUN;
        default: st_d = IDLE;
      endcase
    end else if (ev_lap) begin
      case (st_q)
        IDLE:    st_d = IDLE;
        RUN:     st_d = LAP;
        LAP:     st_d = RUN;
        PAUSE:   st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d  = (st_d == LAP);
    clear_d = ev_lap && ((st_q == IDLE) || (st_q == PAUSE));
  end

  assign state    = st_q;
  assign tick_out = tick_in & ((st_q == RUN) || (st_q == LAP));

endmodule
